// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a synchronous FIFO one byte per frame (8N1).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_W);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;
`endif

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     bit_idx;
  logic [DATA_W-1:0] shift;
  logic              bit_end;
`ifdef UART_TX_PARITY_EN
  logic              par;
`endif

  assign bit_end    = (cnt == CW'(CLKS_PER_BIT - 1));
  assign fifo_rd_en = (state == FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx  <= 1'b1;
          cnt <= '0;
          if (!fifo_empty) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          shift   <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
          par     <= ^fifo_rd_data;
`endif
          tx      <= 1'b0;
          cnt     <= '0;
          bit_idx <= '0;
          state   <= START;
        end
        START: begin
          if (bit_end) begin
            cnt   <= '0;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt   <= '0;
            shift <= {1'b0, shift[DATA_W-1:1]};
            if (bit_idx == IW'(DATA_W - 1)) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              tx      <= par;
              state   <= PARITY;
`else
              tx      <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              // shift is updated on this same edge, so the next bit is shift[1]
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt   <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            cnt     <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
            tx_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural 16x8 FIFO feeding the DUT, frame decoder
// on tx checked against a scoreboard of expected frames.
module tb_fifo_uart_tx;
  localparam int unsigned C  = 4;
  localparam int unsigned DW = 8;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FB = DW + 3;
`else
  localparam int unsigned FB = DW + 2;
`endif
  localparam int unsigned NTR = 80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic f_rst = 1'b1;
  logic fifo_empty, fifo_rd_en, tx, busy, tx_done;
  logic [DW-1:0] fifo_rd_data;
  logic wr_req = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic [DW-1:0] fmem [16];
  logic [3:0] wp, rp;
  logic [4:0] fcount;
  logic wr_ok, rd_ok;

  int unsigned n_tests = 0, n_fail = 0, rd_count = 0, bad_pop = 0;
  logic [10:0] sb [$];

  typedef struct {
    logic [DW-1:0] data;
    logic          par;
  } vec_t;
  vec_t vt [8];

  logic tr_tx [NTR];
  logic tr_busy [NTR];
  logic tr_rd [NTR];
  logic tr_done [NTR];

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(C), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .tx           (tx),
    .busy         (busy),
    .tx_done      (tx_done)
  );

  assign fifo_empty = (fcount == 5'd0);
  assign wr_ok = wr_req && (fcount != 5'd16);
  assign rd_ok = fifo_rd_en && (fcount != 5'd0);

  always @(posedge clk or posedge f_rst) begin
    if (f_rst) begin
      wp <= '0;
      rp <= '0;
      fcount <= '0;
      fifo_rd_data <= '0;
    end else begin
      if (wr_ok) begin
        fmem[wp] <= wr_data;
        wp <= wp + 4'd1;
      end
      if (rd_ok) begin
        fifo_rd_data <= fmem[rp];
        rp <= rp + 4'd1;
      end
      fcount <= 5'(fcount + 5'(wr_ok) - 5'(rd_ok));
    end
  end

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_count <= rd_count + 1;
      if (fifo_empty) bad_pop <= bad_pop + 1;
    end
  end

  function automatic logic [10:0] make_frame(input logic [DW-1:0] d, input logic p);
    logic [10:0] f;
    f = '0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9] = p;
    f[10] = 1'b1;
`else
    f[9] = 1'b1;
    if (p) f[10] = 1'b0;
`endif
    return f;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_fifo(input logic [DW-1:0] d);
    @(posedge clk); #1;
    wr_req = 1'b1;
    wr_data = d;
    @(posedge clk); #1;
    wr_req = 1'b0;
  endtask

  // Caller must be at a negedge; returns at the negedge after the stop bit.
  task automatic recv_frame(output int unsigned gap);
    logic [10:0] act;
    bit stable;
    int unsigned w;
    act = '0;
    stable = 1'b1;
    w = 0;
    while (tx !== 1'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    gap = w;
    if (tx !== 1'b0) begin
      n_tests++;
      n_fail++;
      $display("FAIL start_timeout: no start bit after %0d cycles, expected one", w);
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    for (int b = 0; b < int'(FB); b++) begin
      for (int j = 0; j < int'(C); j++) begin
        if (j == 0) act[b] = tx;
        else if (tx !== act[b]) stable = 1'b0;
        @(negedge clk);
      end
    end
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_underflow: got frame 0x%0h, expected no frame", act);
    end else begin
      check("frame", 64'(act), 64'(sb.pop_front()));
    end
    check("bit_hold", 64'(stable), 64'(1));
    check("tx_done_pulse", 64'(tx_done), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned g, base, quiet, bad_gap;
    int rd_pulses, busy_cyc, done_pulses, rd_idx, f, done_idx, w;
    logic [63:0] act_pat, exp_pat;
    logic [10:0] fr;

    vt[0] = '{8'hA5, 1'b0};
    vt[1] = '{8'h07, 1'b1};
    vt[2] = '{8'h00, 1'b0};
    vt[3] = '{8'hFF, 1'b0};
    vt[4] = '{8'h3C, 1'b0};
    vt[5] = '{8'h01, 1'b1};
    vt[6] = '{8'h80, 1'b1};
    vt[7] = '{8'hD6, 1'b1};

    // Reset held while the FIFO already holds a byte
    repeat (2) @(posedge clk);
    #1 f_rst = 1'b0;
    write_fifo(8'hA5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reset_outputs", 64'({tx, busy, fifo_rd_en, tx_done}), 64'(4'b1000));
    end
    check("no_pop_in_reset", 64'(rd_count), 64'(0));

    // Cycle-accurate trace of one frame after reset release
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < int'(NTR); k++) begin
      @(negedge clk);
      tr_tx[k] = tx;
      tr_busy[k] = busy;
      tr_rd[k] = fifo_rd_en;
      tr_done[k] = tx_done;
    end
    rd_pulses = 0; busy_cyc = 0; done_pulses = 0;
    rd_idx = -1; f = -1; done_idx = -1;
    for (int k = 0; k < int'(NTR); k++) begin
      if (tr_rd[k]) begin
        rd_pulses++;
        if (rd_idx < 0) rd_idx = k;
      end
      if (tr_busy[k]) busy_cyc++;
      if (tr_done[k]) begin
        done_pulses++;
        if (done_idx < 0) done_idx = k;
      end
      if (!tr_tx[k] && f < 0) f = k;
    end
    fr = make_frame(8'hA5, 1'b0);
    act_pat = '0;
    exp_pat = '0;
    for (int b = 0; b < int'(FB); b++) begin
      for (int j = 0; j < int'(C); j++) begin
        exp_pat[b*C+j] = fr[b];
        act_pat[b*C+j] = (f >= 0 && f + b*int'(C) + j < int'(NTR)) ? tr_tx[f + b*int'(C) + j] : 1'bx;
      end
    end
    check("rd_pulses", 64'(rd_pulses), 64'(1));
    check("tx_fall_latency", 64'(f - rd_idx), 64'(2));
    check("tx_pattern", act_pat, exp_pat);
    check("busy_cycles", 64'(busy_cyc), 64'(FB*C + 2));
    check("tx_done_count", 64'(done_pulses), 64'(1));
    check("tx_done_pos", 64'(done_idx), 64'(f + int'(FB*C)));
    check("busy_fall_edge", 64'((done_idx > 0) ? {tr_busy[done_idx-1], tr_busy[done_idx]} : 2'bxx), 64'(2'b10));

    // Table of single-byte frames
    for (int i = 0; i < 8; i++) begin
      sb.push_back(make_frame(vt[i].data, vt[i].par));
      write_fifo(vt[i].data);
      @(negedge clk);
      recv_frame(g);
    end

    // Back-to-back frames
    base = rd_count;
    fork
      begin
        sb.push_back(make_frame(8'h00, 1'b0)); write_fifo(8'h00);
        sb.push_back(make_frame(8'hFF, 1'b0)); write_fifo(8'hFF);
        sb.push_back(make_frame(8'h3C, 1'b0)); write_fifo(8'h3C);
      end
      begin
        @(negedge clk);
        recv_frame(g);
        recv_frame(g);
        check("b2b_gap", 64'(g), 64'(1 + 2));
        recv_frame(g);
        check("b2b_gap", 64'(g), 64'(1 + 2));
      end
    join
    check("b2b_pops", 64'(rd_count - base), 64'(3));
    check("b2b_end_state", 64'({fifo_empty, tx}), 64'(2'b11));

    // Full drain of 16 bytes
    base = rd_count;
    bad_gap = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          sb.push_back(make_frame(8'(i), ^(8'(i))));
          write_fifo(8'(i));
        end
      end
      begin
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
          recv_frame(g);
          if (i > 0 && g != 3) bad_gap++;
        end
        check("drain_busy_fall", 64'({tx_done, busy}), 64'(2'b10));
      end
    join
    check("drain_gaps", 64'(bad_gap), 64'(0));
    check("drain_pops", 64'(rd_count - base), 64'(16));
    check("no_pop_while_empty", 64'(bad_pop), 64'(0));

    // Reset during data bit 3 of 0x55
    sb.push_back(make_frame(8'h55, 1'b0));
    write_fifo(8'h55);
    @(negedge clk);
    w = 0;
    while (tx !== 1'b0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("mid_start_seen", 64'(tx), 64'(0));
    repeat (4*C + 1) @(negedge clk);
    rst = 1'b1;
    f_rst = 1'b1;
    #1;
    check("rst_mid_tx", 64'(tx), 64'(1));
    check("rst_mid_busy", 64'(busy), 64'(0));
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    f_rst = 1'b0;
    base = rd_count;
    quiet = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) quiet++;
    end
    check("idle_after_rst", 64'(quiet), 64'(0));
    check("no_refetch", 64'(rd_count - base), 64'(0));

    sb.push_back(make_frame(8'h81, 1'b0));
    write_fifo(8'h81);
    @(negedge clk);
    recv_frame(g);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
